// File: rtl/usb_rx_packet_parser.sv
// USB receive packet parser: decodes PID, token fields and data payloads from
// a byte-wide receive stream. The data payload is passed to a FIFO with the
// trailing CRC16 stripped by a two-byte hold-back register.
module usb_rx_packet_parser #(
    parameter int unsigned MAX_PAYLOAD = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        getPacketEn,
    input  logic [7:0]  RxCtrlIn,
    input  logic [7:0]  RxDataIn,
    input  logic        RxDataInWEn,
    input  logic        noActivityTimeOut,
    input  logic        fifoFull,
    output logic [7:0]  fifoData,
    output logic        fifoWEn,
    output logic        busy,
    output logic        packetReady,
    output logic [3:0]  pid,
    output logic [6:0]  addr,
    output logic [3:0]  endp,
    output logic [10:0] frameNum,
    output logic [10:0] payloadLen,
    output logic [5:0]  status
);

    localparam logic [7:0]  CTRL_START  = 8'h00;
    localparam logic [7:0]  CTRL_STREAM = 8'h01;
    localparam logic [7:0]  CTRL_STOP   = 8'h02;
    localparam logic [3:0]  PID_SOF     = 4'h5;
    localparam logic [10:0] LEN_MAX     = 11'(MAX_PAYLOAD);

    localparam int unsigned ST_CRC = 0;
    localparam int unsigned ST_BS  = 1;
    localparam int unsigned ST_PID = 2;
    localparam int unsigned ST_OVF = 3;
    localparam int unsigned ST_TO  = 4;
    localparam int unsigned ST_LEN = 5;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_START,
        WAIT_PID,
        TOKEN1,
        TOKEN2,
        DATA,
        WAIT_STOP,
        DONE
    } state_t;

    state_t      r_state;
    logic [7:0]  r_fifo_data;
    logic        r_fifo_wen;
    logic        r_busy;
    logic        r_ready;
    logic [3:0]  r_pid;
    logic [6:0]  r_addr;
    logic [3:0]  r_endp;
    logic [10:0] r_frame;
    logic [10:0] r_len;
    logic [5:0]  r_status;
    logic [7:0]  r_b1;
    logic        r_len_chk;
    logic [7:0]  r_hold0;
    logic [7:0]  r_hold1;
    logic [1:0]  r_hold_cnt;

    state_t      w_state_nxt;
    logic [7:0]  w_fifo_data_nxt;
    logic        w_fifo_wen_nxt;
    logic        w_busy_nxt;
    logic        w_ready_nxt;
    logic [3:0]  w_pid_nxt;
    logic [6:0]  w_addr_nxt;
    logic [3:0]  w_endp_nxt;
    logic [10:0] w_frame_nxt;
    logic [10:0] w_len_nxt;
    logic [5:0]  w_status_nxt;
    logic [7:0]  w_b1_nxt;
    logic        w_len_chk_nxt;
    logic [7:0]  w_hold0_nxt;
    logic [7:0]  w_hold1_nxt;
    logic [1:0]  w_hold_cnt_nxt;
    logic        w_rx;

    logic w_start;
    logic w_stream;
    logic w_stop;

    assign w_start  = RxDataInWEn && (RxCtrlIn == CTRL_START);
    assign w_stream = RxDataInWEn && (RxCtrlIn == CTRL_STREAM);
    assign w_stop   = RxDataInWEn && (RxCtrlIn == CTRL_STOP);

    // State and registered-output update
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_fifo_data <= '0;
            r_fifo_wen  <= 1'b0;
            r_busy      <= 1'b0;
            r_ready     <= 1'b0;
            r_pid       <= '0;
            r_addr      <= '0;
            r_endp      <= '0;
            r_frame     <= '0;
            r_len       <= '0;
            r_status    <= '0;
            r_b1        <= '0;
            r_len_chk   <= 1'b0;
            r_hold0     <= '0;
            r_hold1     <= '0;
            r_hold_cnt  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_fifo_data <= w_fifo_data_nxt;
            r_fifo_wen  <= w_fifo_wen_nxt;
            r_busy      <= w_busy_nxt;
            r_ready     <= w_ready_nxt;
            r_pid       <= w_pid_nxt;
            r_addr      <= w_addr_nxt;
            r_endp      <= w_endp_nxt;
            r_frame     <= w_frame_nxt;
            r_len       <= w_len_nxt;
            r_status    <= w_status_nxt;
            r_b1        <= w_b1_nxt;
            r_len_chk   <= w_len_chk_nxt;
            r_hold0     <= w_hold0_nxt;
            r_hold1     <= w_hold1_nxt;
            r_hold_cnt  <= w_hold_cnt_nxt;
        end
    end

    // Next-state and next-output decode
    always_comb begin
        w_state_nxt     = r_state;
        w_fifo_data_nxt = r_fifo_data;
        w_fifo_wen_nxt  = 1'b0;
        w_pid_nxt       = r_pid;
        w_addr_nxt      = r_addr;
        w_endp_nxt      = r_endp;
        w_frame_nxt     = r_frame;
        w_len_nxt       = r_len;
        w_status_nxt    = r_status;
        w_b1_nxt        = r_b1;
        w_len_chk_nxt   = r_len_chk;
        w_hold0_nxt     = r_hold0;
        w_hold1_nxt     = r_hold1;
        w_hold_cnt_nxt  = r_hold_cnt;
        w_rx            = 1'b0;

        case (r_state)
            IDLE: begin
                if (getPacketEn) begin
                    w_state_nxt  = WAIT_START;
                    w_status_nxt = '0;
                    w_len_nxt    = '0;
                end
            end
            WAIT_START: begin
                if (w_start) begin
                    w_state_nxt = WAIT_PID;
                end else if (noActivityTimeOut) begin
                    w_state_nxt          = DONE;
                    w_status_nxt[ST_TO]  = 1'b1;
                end
            end
            WAIT_PID: begin
                w_rx = 1'b1;
                if (w_stream) begin
                    w_pid_nxt = RxDataIn[3:0];
                    if (RxDataIn[3:0] != ~RxDataIn[7:4]) begin
                        w_status_nxt[ST_PID] = 1'b1;
                        w_len_chk_nxt        = 1'b0;
                        w_state_nxt          = WAIT_STOP;
                    end else begin
                        case (RxDataIn[1:0])
                            2'b01: w_state_nxt = TOKEN1;
                            2'b11: begin
                                w_state_nxt    = DATA;
                                w_hold_cnt_nxt = 2'd0;
                            end
                            default: begin
                                w_len_chk_nxt = 1'b1;
                                w_state_nxt   = WAIT_STOP;
                            end
                        endcase
                    end
                end
            end
            TOKEN1: begin
                w_rx = 1'b1;
                if (w_stream) begin
                    w_b1_nxt    = RxDataIn;
                    w_state_nxt = TOKEN2;
                end
            end
            TOKEN2: begin
                w_rx = 1'b1;
                if (w_stream) begin
                    // SOF carries a frame number; other tokens carry address/endpoint
                    if (r_pid == PID_SOF) begin
                        w_frame_nxt = {RxDataIn[2:0], r_b1};
                    end else begin
                        w_addr_nxt = r_b1[6:0];
                        w_endp_nxt = {RxDataIn[2:0], r_b1[7]};
                    end
                    w_len_chk_nxt = 1'b1;
                    w_state_nxt   = WAIT_STOP;
                end
            end
            DATA: begin
                w_rx = 1'b1;
                if (w_stream) begin
                    if (r_hold_cnt == 2'd2) begin
                        // Oldest held byte is now known not to be CRC
                        if (fifoFull || (r_len == LEN_MAX)) begin
                            w_status_nxt[ST_OVF] = 1'b1;
                        end else begin
                            w_fifo_wen_nxt  = 1'b1;
                            w_fifo_data_nxt = r_hold0;
                            w_len_nxt       = r_len + 11'd1;
                        end
                        w_hold0_nxt = r_hold1;
                        w_hold1_nxt = RxDataIn;
                    end else if (r_hold_cnt == 2'd1) begin
                        w_hold1_nxt    = RxDataIn;
                        w_hold_cnt_nxt = 2'd2;
                    end else begin
                        w_hold0_nxt    = RxDataIn;
                        w_hold_cnt_nxt = 2'd1;
                    end
                end
            end
            WAIT_STOP: begin
                w_rx = 1'b1;
                if (w_stream && r_len_chk) begin
                    w_status_nxt[ST_LEN] = 1'b1;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // START restarts and STOP terminates from every receiving state
        if (w_rx) begin
            if (w_start) begin
                w_state_nxt    = WAIT_PID;
                w_status_nxt   = '0;
                w_len_nxt      = '0;
                w_hold_cnt_nxt = 2'd0;
            end else if (w_stop) begin
                w_status_nxt[ST_CRC] = r_status[ST_CRC] | RxDataIn[0];
                w_status_nxt[ST_BS]  = r_status[ST_BS] | RxDataIn[1];
                if ((r_state == TOKEN1) || (r_state == TOKEN2) ||
                    ((r_state == DATA) && (r_hold_cnt != 2'd2))) begin
                    w_status_nxt[ST_LEN] = 1'b1;
                end
                w_hold_cnt_nxt = 2'd0;
                w_state_nxt    = DONE;
            end
        end

        w_busy_nxt  = (w_state_nxt != IDLE) && (w_state_nxt != DONE);
        w_ready_nxt = (w_state_nxt == DONE);
    end

    assign fifoData    = r_fifo_data;
    assign fifoWEn     = r_fifo_wen;
    assign busy        = r_busy;
    assign packetReady = r_ready;
    assign pid         = r_pid;
    assign addr        = r_addr;
    assign endp        = r_endp;
    assign frameNum    = r_frame;
    assign payloadLen  = r_len;
    assign status      = r_status;

endmodule
